acc_bank: RTL and testbench

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/nibbler_pkg.sv | 17 +
 rtl/acc_alu.sv | 37 +++
 rtl/acc_bank.sv | 58 +++++
 tb/tb_acc_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared op encoding for the accumulator bank
package nibbler_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational result and carry/borrow/shift-out for one accumulator op
module acc_alu
  import nibbler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] din,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  always_comb begin
    res  = acc;
    cout = 1'b0;
    unique case (op_t'(op))
      OP_NOP:  res = acc;
      OP_LOAD: res = din;
      OP_ADD:  {cout, res} = {1'b0, acc} + {1'b0, din};
      // the extra top bit of a widened subtract is exactly the unsigned borrow
      OP_SUB:  {cout, res} = {1'b0, acc} - {1'b0, din};
      OP_AND:  res = acc & din;
      OP_SHL: begin
        res  = {acc[WIDTH-2:0], 1'b0};
        cout = acc[WIDTH-1];
      end
      OP_SHR: begin
        res  = {1'b0, acc[WIDTH-1:1]};
        cout = acc[0];
      end
      OP_CLR:  res = '0;
      default: res = acc;
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of DEPTH accumulators with registered result, flags and valid pulse
module acc_bank
  import nibbler_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [OP_W-1:0]          op,
  input  logic [$clog2(DEPTH)-1:0] sel,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     carry,
  output logic                     zero,
  output logic                     valid
);

  logic [WIDTH-1:0] acc_q [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             in_range;
  logic             do_op;

  // sel can exceed DEPTH-1 when DEPTH is not a power of two
  assign in_range = (32'(sel) < DEPTH);
  assign do_op    = enable && (op != OP_NOP) && in_range;
  assign cur      = in_range ? acc_q[sel] : '0;

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .acc  (cur),
    .din  (dataIn),
    .op   (op),
    .res  (res),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
      dataOut <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      valid <= do_op;
      if (do_op) begin
        acc_q[sel] <= res;
        dataOut    <= res;
        carry      <= cout;
        zero       <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - directed scoreboard bench for acc_bank at WIDTH=4, DEPTH=4
module tb_acc_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] op;
  logic [1:0] sel;
  logic [3:0] dataIn;
  logic [3:0] dataOut;
  logic       carry;
  logic       zero;
  logic       valid;

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_acc [4];
  int   m_d;
  int   m_c;
  int   m_z;

  acc_bank #(.WIDTH(4), .DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .op      (op),
    .sel     (sel),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .carry   (carry),
    .zero    (zero),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_d = 0;
    m_c = 0;
    m_z = 0;
  endtask

  task automatic push_exp(input int v);
    exp_t e;
    e.d = 4'(m_d);
    e.c = 1'(m_c);
    e.z = 1'(m_z);
    e.v = 1'(v);
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      assert ({dataOut, carry, zero, valid} === {e.d, e.c, e.z, e.v}) else begin
        errors++;
        $error("FAIL %s got d=%b c=%b z=%b v=%b expected d=%b c=%b z=%b v=%b",
               tag, dataOut, carry, zero, valid, e.d, e.c, e.z, e.v);
      end
    end
  endtask

  task automatic predict(input logic en, input int o, input int s, input int din);
    int a;
    int r;
    int c;
    if (en && o != 0) begin
      a = m_acc[s];
      c = 0;
      case (o)
        1: r = din;
        2: begin r = (a + din) % 16; c = (a + din > 15) ? 1 : 0; end
        3: begin r = (a - din + 16) % 16; c = (a < din) ? 1 : 0; end
        4: r = a & din;
        5: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
        6: begin r = a / 2; c = a % 2; end
        default: r = 0;
      endcase
      m_acc[s] = r;
      m_d = r;
      m_c = c;
      m_z = (r == 0) ? 1 : 0;
      push_exp(1);
    end else begin
      push_exp(0);
    end
  endtask

  // junk operands mid-cycle must not matter; only the value at the edge counts
  task automatic step(input logic en, input int o, input int s, input int din, input string tag);
    enable = ~en;
    op     = 3'($urandom_range(7));
    dataIn = 4'($urandom_range(15));
    sel    = 2'(s);
    #2;
    enable = en;
    op     = 3'(o);
    dataIn = 4'(din);
    predict(en, o, s, din);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    op     = 3'b001;
    sel    = 2'd0;
    dataIn = 4'b1010;
    model_reset();
    #1;
    push_exp(0);
    check_out("reset_async");
    for (int i = 0; i < 3; i++) begin
      push_exp(0);
      @(posedge clk);
      #1;
      check_out("reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 0, 0, 4'b1010, "nop_after_reset");

    step(1'b1, 1, 0, 4'b1100, "load_s0");
    step(1'b1, 2, 0, 4'b0101, "add_overflow");

    step(1'b1, 1, 1, 4'b0011, "load_s1");
    step(1'b1, 3, 1, 4'b0011, "sub_zero");
    step(1'b1, 3, 1, 4'b0001, "sub_borrow");

    step(1'b1, 1, 2, 4'b1001, "load_s2");
    step(1'b1, 5, 2, 0, "shl");
    step(1'b1, 6, 2, 0, "shr");
    step(1'b0, 2, 2, 4'b0001, "hold_en0_a");
    step(1'b0, 7, 2, 0, "hold_en0_b");
    step(1'b1, 0, 2, 4'b1111, "hold_nop");

    step(1'b1, 1, 0, 4'b0111, "load_s0_b");
    step(1'b1, 1, 3, 4'b1000, "load_s3");
    step(1'b1, 2, 0, 4'b0001, "add_s0");
    step(1'b1, 2, 3, 4'b0000, "add_s3_isolated");
    step(1'b1, 4, 3, 4'b1100, "and_s3");
    step(1'b1, 7, 0, 0, "clr_s0");

    step(1'b1, 2, 1, 4'b0001, "b2b_add_a");
    step(1'b1, 2, 1, 4'b0001, "b2b_add_b");
    reset = 1'b0;
    #2;
    model_reset();
    push_exp(0);
    check_out("mid_reset_async");
    push_exp(0);
    @(posedge clk);
    #1;
    check_out("mid_reset_edge");
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < 4; s++) step(1'b1, 2, s, 0, "post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
